ssd_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit seven-segment display. It holds a double-buffered 4-digit code word and cycles through the digits with a dead-time guard between them. Each cycle it presents one 4-bit code to the downstream BCD-to-segment decoder, together with the matching active-low anode enable. It also applies leading-zero blanking and per-digit blinking by substituting the dark code (4'hF).

---
 rtl/ssd_pkg.sv | 14 +
 rtl/ssd_blink_gen.sv | 28 ++
 rtl/ssd_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared codes, anode patterns and scan state encoding for the 7-segment
// display controller and its helpers.
package ssd_pkg;

  localparam logic [3:0] CODE_DARK  = 4'hF;
  localparam logic [3:0] CODE_MINUS = 4'hE;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  typedef enum logic {
    SHOW  = 1'b0,
    GUARD = 1'b1
  } scan_state_e;

endpackage

// File: rtl/ssd_blink_gen.sv
// Free-running blink divider: phase toggles every BLINK_DIV clock cycles,
// independent of the scan sequence.
module ssd_blink_gen #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic phase
);

  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment scan controller: double-buffered code word,
// SHOW/GUARD multiplexing, leading-zero blanking and per-digit blinking.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic        load,
  input  logic        lz_blank,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  bcd_out,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(BLANK_CYC - 1);

  scan_state_e   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [15:0]   staging, staging_nxt;
  logic [15:0]   shadow, shadow_nxt;
  logic          pending, pending_nxt;
  logic          blink_ph;
  logic          phase_end;
  logic          wrap;
  logic [3:0]    an_nxt;
  logic [3:0]    bcd_nxt;
  logic          fd_nxt;

  ssd_blink_gen #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .clk  (clk),
    .rst_n(rst_n),
    .phase(blink_ph)
  );

  // Displayed code for digit i after blink and leading-zero substitution.
  function automatic logic [3:0] eff_code(input logic [15:0] sh,
                                          input logic [1:0]  i,
                                          input logic        lz,
                                          input logic [3:0]  bm,
                                          input logic        ph);
    logic upper_nz;
    upper_nz = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      if (j >= int'(i) && sh[j*4 +: 4] != 4'h0) upper_nz = 1'b1;
    end
    if (bm[i] && ph)                          eff_code = CODE_DARK;
    else if (lz && i != 2'd0 && !upper_nz)    eff_code = CODE_DARK;
    else                                      eff_code = sh[{i, 2'b00} +: 4];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= GUARD;
      cnt     <= '0;
      idx     <= 2'd3;
      staging <= 16'hFFFF;
      shadow  <= 16'hFFFF;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      staging <= staging_nxt;
      shadow  <= shadow_nxt;
      pending <= pending_nxt;
    end
  end

  // Shadow only changes on the wrap edge, so a frame never mixes two code words.
  always_comb begin
    phase_end   = (state == SHOW) ? (cnt == SHOW_LAST) : (cnt == GUARD_LAST);
    wrap        = (state == GUARD) && phase_end && (idx == 2'd3);
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    idx_nxt     = idx;
    staging_nxt = staging;
    shadow_nxt  = shadow;
    pending_nxt = pending;
    if (phase_end) begin
      cnt_nxt = '0;
      if (state == SHOW) begin
        state_nxt = GUARD;
      end else begin
        state_nxt = SHOW;
        idx_nxt   = idx + 2'd1;
      end
    end
    if (wrap) begin
      if (load || pending) shadow_nxt = load ? digits : staging;
      pending_nxt = 1'b0;
    end else if (load) begin
      staging_nxt = digits;
      pending_nxt = 1'b1;
    end
  end

  always_comb begin
    an_nxt  = AN_OFF;
    bcd_nxt = CODE_DARK;
    fd_nxt  = (state_nxt == GUARD) && (idx_nxt == 2'd3) && (cnt_nxt == GUARD_LAST);
    if (state_nxt == SHOW) begin
      an_nxt  = ~(4'b0001 << idx_nxt);
      bcd_nxt = eff_code(shadow_nxt, idx_nxt, lz_blank, blink_mask, blink_ph);
    end
  end

  // Output stage: anode and code are registered together so they switch on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= AN_OFF;
      bcd_out    <= CODE_DARK;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      bcd_out    <= bcd_nxt;
      frame_done <= fd_nxt;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: directed scenarios plus random traffic compared
// every cycle against a timeline-based reference of the display.
module tb_ssd_scan_ctrl;

  localparam int REFRESH = 8;
  localparam int BLANK   = 2;
  localparam int BLINK   = 64;
  localparam int PER     = REFRESH + BLANK;
  localparam int FRAME   = 4 * PER;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits;
  logic        load;
  logic        lz_blank;
  logic [3:0]  blink_mask;
  logic [3:0]  bcd_out;
  logic [3:0]  an;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  // Reference state: cycles since reset release and the buffered code words.
  int          k;
  logic [15:0] m_stage;
  logic [15:0] m_shadow;
  logic        m_pend;

  ssd_scan_ctrl #(
    .REFRESH_DIV(REFRESH),
    .BLANK_CYC  (BLANK),
    .BLINK_DIV  (BLINK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits    (digits),
    .load      (load),
    .lz_blank  (lz_blank),
    .blink_mask(blink_mask),
    .bcd_out   (bcd_out),
    .an        (an),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: got %h expected %h", tag, k, got, exp);
    end
  endtask

  function automatic bit is_show(input int kk);
    return (kk >= BLANK) && (((kk - BLANK) % PER) < REFRESH);
  endfunction

  function automatic int digit_at(input int kk);
    return ((kk - BLANK) / PER) % 4;
  endfunction

  function automatic bit fd_at(input int kk);
    return (kk >= 1) && (kk + 1 >= BLANK) && (((kk + 1 - BLANK) % FRAME) == 0);
  endfunction

  function automatic logic [3:0] model_code(input int d);
    logic [15:0] upper;
    bit ph;
    ph    = (((k - 1) / BLINK) % 2) == 1;
    upper = m_shadow >> (4 * d);
    if (blink_mask[d] && ph)              return 4'hF;
    if (lz_blank && d >= 1 && upper == 0) return 4'hF;
    return upper[3:0];
  endfunction

  task automatic check_outputs();
    logic [3:0] e_an, e_bcd;
    e_an  = 4'b1111;
    e_bcd = 4'hF;
    if (is_show(k)) begin
      e_an  = ~(4'b0001 << digit_at(k));
      e_bcd = model_code(digit_at(k));
    end
    chk("an", {12'h0, an}, {12'h0, e_an});
    chk("bcd_out", {12'h0, bcd_out}, {12'h0, e_bcd});
    chk("frame_done", {15'h0, frame_done}, {15'h0, fd_at(k)});
  endtask

  task automatic tick();
    bit wr;
    wr = (k + 1 >= BLANK) && (((k + 1 - BLANK) % FRAME) == 0);
    if (wr) begin
      if (load || m_pend) m_shadow = load ? digits : m_stage;
      m_pend = 1'b0;
    end else if (load) begin
      m_stage = digits;
      m_pend  = 1'b1;
    end
    @(posedge clk);
    #1;
    k++;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] v);
    digits = v;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  task automatic model_reset();
    k        = 0;
    m_stage  = 16'hFFFF;
    m_shadow = 16'hFFFF;
    m_pend   = 1'b0;
  endtask

  task automatic wait_show(input int d, input int offs);
    int n;
    n = 0;
    while (!(is_show(k) && digit_at(k) == d && ((k - BLANK) % PER) == offs) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    chk("wait_show_bound", {15'h0, n >= 2 * FRAME}, 16'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    digits     = 16'h0000;
    load       = 1'b0;
    lz_blank   = 1'b0;
    blink_mask = 4'b0000;
    model_reset();
    #12;
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_bcd", {12'h0, bcd_out}, 16'h000F);
    chk("rst_fd", {15'h0, frame_done}, 16'h0);
    chk("rst_shadow", dut.shadow, 16'hFFFF);
    chk("rst_pending", {15'h0, dut.pending}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scan order and dark display before any load.
    run(5);
    do_load(16'h1234);
    run(2 * FRAME);

    // Double buffer: load while digit 1 lit, then two loads in one frame.
    wait_show(1, 3);
    do_load(16'h5678);
    run(2 * FRAME);
    wait_show(0, 2);
    do_load(16'h1111);
    run(7);
    do_load(16'h2468);
    run(2 * FRAME);

    // Load exactly on the frame_done cycle.
    begin
      int n;
      n = 0;
      while (!fd_at(k) && n < 2 * FRAME) begin
        tick();
        n++;
      end
      chk("wait_wrap_bound", {15'h0, n >= 2 * FRAME}, 16'h0);
    end
    chk("fd_seen", {15'h0, frame_done}, 16'h1);
    do_load(16'h9999);
    chk("pending_after_wrap_load", {15'h0, dut.pending}, 16'h0);
    run(FRAME);

    // Leading-zero blanking.
    lz_blank = 1'b1;
    do_load(16'h0040);
    run(2 * FRAME);
    do_load(16'h0000);
    run(2 * FRAME);
    do_load(16'h0E05);
    run(2 * FRAME);
    lz_blank = 1'b0;

    // Blink digit 1.
    blink_mask = 4'b0010;
    do_load(16'h1234);
    run(4 * FRAME);
    blink_mask = 4'b0000;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) lz_blank = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom_range(0, 15));
      digits = 16'($urandom);
      if ($urandom_range(0, 3) == 0) digits = digits & 16'h00FF;
      load = ($urandom_range(0, 19) == 0);
      tick();
    end
    load = 1'b0;
    lz_blank = 1'b0;
    blink_mask = 4'b0000;

    // Asynchronous reset during SHOW of digit 2.
    do_load(16'h4321);
    run(FRAME);
    wait_show(2, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", {12'h0, an}, 16'h000F);
    chk("async_rst_bcd", {12'h0, bcd_out}, 16'h000F);
    chk("async_rst_fd", {15'h0, frame_done}, 16'h0);
    chk("async_rst_shadow", dut.shadow, 16'hFFFF);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(FRAME + 5);
    do_load(16'h8765);
    run(2 * FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
